booth_mul_arbiter: RTL and testbench

//   Shares one sequential Booth multiplier datapath+controller among NREQ requesters.

---
 rtl/booth_mul_arbiter.sv | 148 ++++++++++++++
 tb/tb_booth_mul_arbiter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_mul_arbiter.sv
// Round-robin front end that shares one sequential Booth multiplier among NREQ clients:
// captures the winner's operands, re-arms and starts the multiplier, returns product or timeout.
`timescale 1ns/1ps
module booth_mul_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 8,
  parameter int TMO  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] opa,
  input  logic [NREQ*W-1:0] opb,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [NREQ-1:0]   rsp_err,
  output logic [2*W-1:0]    rsp_data,
  output logic              busy,
  output logic              mul_rst,
  output logic              mul_start,
  output logic [W-1:0]      mul_m,
  output logic [W-1:0]      mul_q,
  input  logic              mul_done,
  input  logic [2*W-1:0]    mul_prod
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(TMO + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLR   = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_RESP  = 3'd4;
  localparam logic [2:0] S_ABORT = 3'd5;

  logic [2:0]      state_r, state_s;
  logic [IW-1:0]   rr_ptr_r, win_r, win_s;
  logic            hit_s, take_s;
  logic [IW:0]     sum_s, cand_s;
  logic [CW-1:0]   cnt_r;
  logic [NREQ-1:0] gnt_r, rsp_valid_r, rsp_err_r;
  logic [2*W-1:0]  rsp_data_r;
  logic            busy_r, mul_rst_r, mul_start_r;
  logic [W-1:0]    mul_m_r, mul_q_r;

  // Round-robin search: first set request at rr_ptr, rr_ptr+1, ... modulo NREQ
  always_comb begin
    win_s  = '0;
    hit_s  = 1'b0;
    sum_s  = '0;
    cand_s = '0;
    take_s = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      sum_s  = {1'b0, rr_ptr_r} + (IW+1)'(k);
      cand_s = (sum_s >= (IW+1)'(NREQ)) ? (sum_s - (IW+1)'(NREQ)) : sum_s;
      take_s = !hit_s && req[cand_s[IW-1:0]];
      win_s  = take_s ? cand_s[IW-1:0] : win_s;
      hit_s  = hit_s | take_s;
    end
  end

  // Next-state logic of the sharing controller
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE:  state_s = hit_s ? S_CLR : S_IDLE;
      S_CLR:   state_s = S_START;
      S_START: state_s = S_WAIT;
      S_WAIT: begin
        if (mul_done) begin
          state_s = S_RESP;
        end else if (cnt_r == CW'(TMO - 1)) begin
          state_s = S_ABORT;
        end else begin
          state_s = S_WAIT;
        end
      end
      S_RESP:  state_s = S_IDLE;
      S_ABORT: state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // State, capture registers and registered outputs; strobes are decoded from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= S_IDLE;
      rr_ptr_r    <= '0;
      win_r       <= '0;
      cnt_r       <= '0;
      gnt_r       <= '0;
      rsp_valid_r <= '0;
      rsp_err_r   <= '0;
      rsp_data_r  <= '0;
      busy_r      <= 1'b0;
      mul_rst_r   <= 1'b0;
      mul_start_r <= 1'b0;
      mul_m_r     <= '0;
      mul_q_r     <= '0;
    end else begin
      state_r     <= state_s;
      busy_r      <= (state_s != S_IDLE);
      mul_rst_r   <= (state_s == S_CLR) || (state_s == S_ABORT);
      mul_start_r <= (state_s == S_START);
      rsp_valid_r <= (state_s == S_RESP)  ? gnt_r : '0;
      rsp_err_r   <= (state_s == S_ABORT) ? gnt_r : '0;
      case (state_r)
        S_IDLE: begin
          if (hit_s) begin
            win_r   <= win_s;
            gnt_r   <= {{(NREQ-1){1'b0}}, 1'b1} << win_s;
            mul_m_r <= opa[win_s*W +: W];
            mul_q_r <= opb[win_s*W +: W];
          end else begin
            gnt_r   <= '0;
          end
        end
        S_CLR: cnt_r <= '0;
        S_WAIT: begin
          cnt_r <= cnt_r + CW'(1);
          if (mul_done) begin
            rsp_data_r <= mul_prod;
          end else begin
            rsp_data_r <= rsp_data_r;
          end
        end
        S_RESP, S_ABORT: begin
          gnt_r    <= '0;
          rr_ptr_r <= (win_r == IW'(NREQ - 1)) ? '0 : (win_r + IW'(1));
        end
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  // The multiplier is held re-armed for the whole time the block itself is in reset
  assign mul_rst   = rst | mul_rst_r;
  assign gnt       = gnt_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_err   = rsp_err_r;
  assign rsp_data  = rsp_data_r;
  assign busy      = busy_r;
  assign mul_start = mul_start_r;
  assign mul_m     = mul_m_r;
  assign mul_q     = mul_q_r;

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Bench for booth_mul_arbiter: behavioural multiplier model, table of single-client vectors,
// scoreboard queue of expected responses, hand sequences for fairness, timeout, abandon, reset.
`timescale 1ns/1ps
module tb_booth_mul_arbiter;

  localparam int LAT = 18;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = 4'b0000;
  logic [31:0] opa = 32'h0, opb = 32'h0;
  logic [3:0]  gnt, rsp_valid, rsp_err;
  logic [15:0] rsp_data, mul_prod;
  logic        busy, mul_rst, mul_start, mul_done;
  logic [7:0]  mul_m, mul_q;

  logic        m_busy, no_done = 1'b0;
  int          m_cnt;
  logic [15:0] m_prod;

  int n_vec = 0;
  int n_err = 0;

  typedef struct { logic [3:0] v; logic [3:0] e; logic [15:0] d; } exp_t;
  exp_t sbq[$];

  typedef struct { int idx; logic [7:0] a; logic [7:0] b; logic [15:0] prod; } vec_t;
  vec_t tbl[7];

  booth_mul_arbiter #(.NREQ(4), .W(8), .TMO(64)) dut (
    .clk(clk), .rst(rst), .req(req), .opa(opa), .opb(opb),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_data(rsp_data),
    .busy(busy), .mul_rst(mul_rst), .mul_start(mul_start), .mul_m(mul_m), .mul_q(mul_q),
    .mul_done(mul_done), .mul_prod(mul_prod)
  );

  always #5 clk = ~clk;

  // Multiplier stand-in: fixed latency, signed product, done held until re-armed
  always @(posedge clk) begin
    if (mul_rst) begin
      mul_done <= 1'b0;
      m_busy   <= 1'b0;
      m_cnt    <= 0;
    end else if (mul_start) begin
      m_busy <= 1'b1;
      m_cnt  <= 0;
      m_prod <= {{8{mul_m[7]}}, mul_m} * {{8{mul_q[7]}}, mul_q};
    end else if (m_busy) begin
      if (m_cnt == LAT - 1) begin
        m_busy   <= 1'b0;
        mul_done <= !no_done;
      end
      m_cnt <= m_cnt + 1;
    end
  end
  assign mul_prod = m_prod;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic push(input int idx, input logic [15:0] d, input bit err);
    exp_t x;
    x.v = err ? 4'b0000 : (4'b0001 << idx);
    x.e = err ? (4'b0001 << idx) : 4'b0000;
    x.d = d;
    sbq.push_back(x);
  endtask

  task automatic set_ops(input int idx, input logic [7:0] a, input logic [7:0] b);
    opa[idx*8 +: 8] = a;
    opb[idx*8 +: 8] = b;
  endtask

  // Scoreboard: every response pulse must match the oldest pending expectation
  always @(negedge clk) begin
    if (!rst && ((rsp_valid | rsp_err) != 4'b0000)) begin
      if (sbq.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_rsp: got valid=%b err=%b, expected no response", rsp_valid, rsp_err);
      end else begin
        exp_t x;
        x = sbq.pop_front();
        chk("rsp_valid", {28'h0, rsp_valid}, {28'h0, x.v});
        chk("rsp_err", {28'h0, rsp_err}, {28'h0, x.e});
        if (x.v != 4'b0000) chk("rsp_data", {16'h0, rsp_data}, {16'h0, x.d});
        chk("onehot", {31'h0, $onehot0(gnt) && $onehot0(rsp_valid) && $onehot0(rsp_err)
                              && ((rsp_valid & rsp_err) == 4'b0000)}, 32'd1);
      end
    end
  end

  task automatic wait_rsp(output logic [3:0] who);
    who = 4'b0000;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if ((rsp_valid | rsp_err) != 4'b0000) begin
        who = rsp_valid | rsp_err;
        break;
      end
    end
    if (who == 4'b0000) begin
      n_vec++;
      n_err++;
      $display("FAIL rsp_wait: no response within 300 cycles, expected one");
    end
  endtask

  task automatic wait_start();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mul_start) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      n_vec++;
      n_err++;
      $display("FAIL start_wait: mul_start not seen within 20 cycles, expected 1");
    end
  endtask

  // Raise the masked requests together; each drops right after its own response
  task automatic run_group(input logic [3:0] mask);
    logic [3:0] pend, who;
    pend = mask;
    req  = req | mask;
    while (pend != 4'b0000) begin
      wait_rsp(who);
      if (who == 4'b0000) break;
      req  = req & ~who;
      pend = pend & ~who;
    end
    req = req & ~mask;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    logic [3:0] who;
    tbl[0] = '{1, 8'h80, 8'h80, 16'h4000};
    tbl[1] = '{2, 8'h7F, 8'h7F, 16'h3F01};
    tbl[2] = '{3, 8'h80, 8'h7F, 16'hC080};
    tbl[3] = '{0, 8'hFF, 8'hFF, 16'h0001};
    tbl[4] = '{1, 8'h00, 8'h55, 16'h0000};
    tbl[5] = '{2, 8'hFF, 8'h01, 16'hFFFF};
    tbl[6] = '{3, 8'h7F, 8'h80, 16'hC080};

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_gnt", {28'h0, gnt}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_mul_rst", {31'h0, mul_rst}, 32'h1);
    chk("rst_mul_start", {31'h0, mul_start}, 32'h0);
    chk("rst_rsp_data", {16'h0, rsp_data}, 32'h0);
    chk("rst_mul_mq", {16'h0, mul_m, mul_q}, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // T1: single request, latency and product 7 * -3
    set_ops(0, 8'h07, 8'hFD);
    push(0, 16'hFFEB, 1'b0);
    req = 4'b0001;
    @(negedge clk);
    chk("t1_gnt", {28'h0, gnt}, 32'h1);
    chk("t1_busy", {31'h0, busy}, 32'h1);
    chk("t1_clr_mul_rst", {31'h0, mul_rst}, 32'h1);
    @(negedge clk);
    chk("t1_mul_start", {31'h0, mul_start}, 32'h1);
    chk("t1_mul_mq", {16'h0, mul_m, mul_q}, 32'h07FD);
    wait_rsp(who);
    chk("t1_who", {28'h0, who}, 32'h1);
    req = 4'b0000;
    @(negedge clk);
    chk("t1_busy_after", {31'h0, busy}, 32'h0);
    chk("t1_gnt_after", {28'h0, gnt}, 32'h0);

    // Table of single-client vectors; last one leaves rr_ptr at 0
    for (int v = 0; v < 7; v++) begin
      set_ops(tbl[v].idx, tbl[v].a, tbl[v].b);
      push(tbl[v].idx, tbl[v].prod, 1'b0);
      run_group(4'b0001 << tbl[v].idx);
    end

    // T2: all four requesting -> 0,1,2,3; then 0 and 2 -> 0,2
    for (int i = 0; i < 4; i++) set_ops(i, 8'(i + 1), 8'h03);
    push(0, 16'h0003, 1'b0);
    push(1, 16'h0006, 1'b0);
    push(2, 16'h0009, 1'b0);
    push(3, 16'h000C, 1'b0);
    run_group(4'b1111);
    push(0, 16'h0003, 1'b0);
    push(2, 16'h0009, 1'b0);
    run_group(4'b0101);

    // T3: bring rr_ptr to 2, then 0011 -> 0,1 and 1001 -> 3,0
    push(1, 16'h0006, 1'b0);
    run_group(4'b0010);
    push(0, 16'h0003, 1'b0);
    push(1, 16'h0006, 1'b0);
    run_group(4'b0011);
    push(3, 16'h000C, 1'b0);
    push(0, 16'h0003, 1'b0);
    run_group(4'b1001);

    // T4: multiplier never finishes -> abort 64 cycles into WAIT
    no_done = 1'b1;
    set_ops(2, 8'h05, 8'h05);
    push(2, 16'h0000, 1'b1);
    req = 4'b0100;
    wait_start();
    for (int c = 1; c <= 65; c++) begin
      @(negedge clk);
      if (c == 64) chk("t4_no_err_early", {28'h0, rsp_err}, 32'h0);
    end
    chk("t4_rsp_err", {28'h0, rsp_err}, 32'h4);
    chk("t4_mul_rst", {31'h0, mul_rst}, 32'h1);
    chk("t4_no_valid", {28'h0, rsp_valid}, 32'h0);
    chk("t4_data_held", {16'h0, rsp_data}, 32'h0003);
    req = 4'b0000;
    no_done = 1'b0;
    set_ops(1, 8'h02, 8'h03);
    push(1, 16'h0006, 1'b0);
    run_group(4'b0010);

    // T5: requester drops and changes operands mid-operation
    set_ops(1, 8'h80, 8'h80);
    push(1, 16'h4000, 1'b0);
    req = 4'b0010;
    wait_start();
    repeat (3) @(negedge clk);
    set_ops(1, 8'h11, 8'h22);
    req = 4'b0000;
    @(negedge clk);
    chk("t5_mul_mq", {16'h0, mul_m, mul_q}, 32'h8080);
    wait_rsp(who);
    chk("t5_who", {28'h0, who}, 32'h2);

    // T6: reset in WAIT, no response, arbitration restarts from rr_ptr 0
    set_ops(3, 8'h03, 8'h03);
    req = 4'b1000;
    wait_start();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    req = 4'b0000;
    #1;
    chk("t6_mul_rst_comb", {31'h0, mul_rst}, 32'h1);
    @(negedge clk);
    chk("t6_gnt", {28'h0, gnt}, 32'h0);
    chk("t6_busy", {31'h0, busy}, 32'h0);
    chk("t6_rsp", {24'h0, rsp_valid, rsp_err}, 32'h0);
    chk("t6_rsp_data", {16'h0, rsp_data}, 32'h0);
    chk("t6_mul_mq", {16'h0, mul_m, mul_q}, 32'h0);
    chk("t6_mul_start", {31'h0, mul_start}, 32'h0);
    chk("t6_mul_rst", {31'h0, mul_rst}, 32'h1);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    set_ops(1, 8'h02, 8'h03);
    set_ops(2, 8'h04, 8'h05);
    push(1, 16'h0006, 1'b0);
    push(2, 16'h0014, 1'b0);
    run_group(4'b0110);
    push(2, 16'h0014, 1'b0);
    run_group(4'b0100);

    repeat (3) @(negedge clk);
    chk("sb_empty", sbq.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
